lcd_char_feeder: RTL and testbench
==================================

// Module: lcd_char_feeder
// PURPOSE
//  Character buffer and handshake master directly upstream of the LCD character writer.
//  Upstream logic (keypad decoder, UART receiver, test pattern source) pushes bytes into a FIFO.
//  The feeder drains the FIFO one byte at a time into the LCD writer's ready/write_Enabled/iData port.
//  It never drives the LCD writer while its ready is low, so no byte is lost across the ~40us write time.
// PARAMETERS
//  DEPTH   16  FIFO entries; power of two, 2..256
//  ADDR_W  4   log2(DEPTH); pointer width
//  BUSY_TO 3   cycles to wait for LCD ready to drop after a write strobe before giving up
// PORTS
//  Clock        in   1         system clock (50 MHz)
//  Reset_n      in   1         asynchronous, active-low reset
//  iPush        in   1         push iChar this cycle
//  iChar        in   8         byte to enqueue
//  iClearOvf    in   1         clears oOverflow
//  oFull        out  1         FIFO holds DEPTH entries
//  oEmpty       out  1         FIFO holds 0 entries
//  oCount       out  ADDR_W+1  current occupancy, 0..DEPTH
//  oOverflow    out  1         sticky: a push was dropped
//  iLCD_Ready   in   1         ready output of LCD writer (high only in its idle state)
//  oLCD_Write   out  1         write_Enabled to LCD writer; single-cycle strobe
//  oLCD_Data    out  8         iData to LCD writer; valid while oLCD_Write=1
// BEHAVIOUR
//  Reset (async, Reset_n=0): pointers=0, oCount=0, oEmpty=1, oFull=0, oOverflow=0.
//   Also oLCD_Write=0, oLCD_Data=8'h00, FSM=S_IDLE, timeout counter=0.
//   Reset mid-transfer abandons the byte; the FIFO contents are discarded.
//  All outputs are registered. oFull/oEmpty/oCount reflect the state after the previous edge.
//  Push: accepted when iPush=1 and (count<DEPTH or pop in same cycle); writes mem[wr_ptr], wr_ptr++.
//   Push while full with no pop: byte dropped, oOverflow<=1.
//  Pointers wrap modulo DEPTH. Occupancy comes from a separate ADDR_W+1 counter, not a pointer difference.
//  Simultaneous accepted push+pop: count unchanged. An empty FIFO never pops.
//   A push into an empty FIFO is visible to the FSM on the next cycle, so there is no same-cycle bypass.
//  oOverflow: set wins over iClearOvf when both occur in the same cycle.
//  FSM:
//   S_IDLE: if !oEmpty && iLCD_Ready -> S_ISSUE; pop head; oLCD_Data<=mem[rd_ptr]; oLCD_Write<=1.
//   S_ISSUE (1 cycle, strobe high): next edge oLCD_Write<=0, oLCD_Data held; tmo<=0 -> S_WAIT_BUSY.
//   S_WAIT_BUSY: iLCD_Ready=0 -> S_WAIT_READY.
//    Otherwise tmo++; when tmo==BUSY_TO -> S_IDLE (writer missed the strobe; byte counted as sent).
//   S_WAIT_READY: iLCD_Ready=1 -> S_IDLE. No timeout here, because the LCD write can take >2000 cycles.
//  Latency: a push into an empty FIFO with iLCD_Ready=1 raises oLCD_Write 2 edges later.
//   Back-to-back bytes are throttled solely by the LCD writer's ready.
//  While the LCD is initialising (iLCD_Ready=0 for ~20ms), bytes accumulate; the FIFO drains once ready rises.
//  oLCD_Write is never high for 2 consecutive cycles and never high while the FSM is outside S_ISSUE.
// CONFIGURATION
//  LCD_FEED_FILTER_EN defined: at push, bytes outside 8'h20..8'h7E are stored as 8'h20 (space).
//   This keeps control codes off the display.
//  Undefined: bytes are stored unmodified. The port list is identical in both builds.
// TESTING
//  1 Reset_n=0 mid-S_WAIT_READY -> all outputs at reset values immediately (async); oCount=0.
//  2 iLCD_Ready=1, push 8'h41 -> oLCD_Write=1 with oLCD_Data=8'h41 exactly 2 edges later, for 1 cycle.
//   Drop ready the next cycle -> no further strobe.
//  3 Hold iLCD_Ready=0, push 17 bytes 0x30..0x40 (DEPTH=16) -> oFull=1, oCount=16, oOverflow=1.
//   Release ready with a model writer -> 0x30..0x3F sent in order; 0x40 absent.
//  4 FIFO count=16, iPush and pop in the same cycle -> push accepted, oCount stays 16, oOverflow unchanged.
//  5 Keep iLCD_Ready=1 after a strobe -> return to S_IDLE after BUSY_TO cycles; next byte is strobed.
//  6 With LCD_FEED_FILTER_EN, push 8'h0A, 8'h7F, 8'h7E -> emitted 8'h20, 8'h20, 8'h7E.
//   Without the macro -> 8'h0A, 8'h7F, 8'h7E.

Source files
------------

// File: rtl/lcd_char_feeder.sv
// Byte FIFO feeding the LCD character writer over its ready/write/data handshake.
// Optional build macro LCD_FEED_FILTER_EN replaces non-printable bytes with a space at push.
module lcd_char_feeder #(
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int BUSY_TO = 3
) (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              iPush,
   input  logic [7:0]        iChar,
   input  logic              iClearOvf,
   output logic              oFull,
   output logic              oEmpty,
   output logic [ADDR_W:0]   oCount,
   output logic              oOverflow,
   input  logic              iLCD_Ready,
   output logic              oLCD_Write,
   output logic [7:0]        oLCD_Data
);

   localparam int TMO_W = (BUSY_TO > 1) ? $clog2(BUSY_TO + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_WAIT_READY
   } state_t;

   state_t            state;
   logic [TMO_W-1:0]  tmo;
   logic [7:0]        mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr, rdPtr;
   logic [ADDR_W:0]   cntNext;
   logic [7:0]        storeChar;
   logic              pop, pushOk;

   // The FSM only looks at the registered empty flag, so a fresh push waits a cycle.
   assign pop    = (state == S_IDLE) && !oEmpty && iLCD_Ready;
   assign pushOk = iPush && (!oFull || pop);

`ifdef LCD_FEED_FILTER_EN
   assign storeChar = (iChar < 8'h20 || iChar > 8'h7E) ? 8'h20 : iChar;
`else
   assign storeChar = iChar;
`endif

   always_comb begin
      cntNext = oCount;
      case ({pushOk, pop})
         2'b10:   cntNext = oCount + 1'b1;
         2'b01:   cntNext = oCount - 1'b1;
         default: cntNext = oCount;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (pushOk) mem[wrPtr] <= storeChar;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         oCount    <= '0;
         oEmpty    <= 1'b1;
         oFull     <= 1'b0;
         oOverflow <= 1'b0;
      end else begin
         if (pushOk) wrPtr <= wrPtr + 1'b1;
         if (pop)    rdPtr <= rdPtr + 1'b1;
         oCount <= cntNext;
         oEmpty <= (cntNext == '0);
         oFull  <= (cntNext == (ADDR_W+1)'(DEPTH));
         // A dropped byte outranks a clear arriving in the same cycle.
         if (iPush && oFull && !pop) oOverflow <= 1'b1;
         else if (iClearOvf)         oOverflow <= 1'b0;
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= S_IDLE;
         tmo        <= '0;
         oLCD_Write <= 1'b0;
         oLCD_Data  <= 8'h00;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  oLCD_Data  <= mem[rdPtr];
                  oLCD_Write <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               oLCD_Write <= 1'b0;
               tmo        <= '0;
               state      <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               // Writer never went busy: treat the strobe as missed and move on.
               if (!iLCD_Ready)                        state <= S_WAIT_READY;
               else if (tmo + 1'b1 == TMO_W'(BUSY_TO)) state <= S_IDLE;
               else                                    tmo   <= tmo + 1'b1;
            end
            S_WAIT_READY: begin
               if (iLCD_Ready) state <= S_IDLE;
            end
            default: begin
               oLCD_Write <= 1'b0;
               state      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_char_feeder.sv
// Directed bench for lcd_char_feeder with a simple model of the LCD writer's ready line.
`timescale 1ns/1ps
module tb_lcd_char_feeder;

   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int BUSY_TO = 3;

   logic            Clock = 1'b0;
   logic            Reset_n;
   logic            iPush, iClearOvf, iLCD_Ready;
   logic [7:0]      iChar;
   logic            oFull, oEmpty, oOverflow, oLCD_Write;
   logic [ADDR_W:0] oCount;
   logic [7:0]      oLCD_Data;

   int checks = 0;
   int errors = 0;
   logic [7:0] rx[$];

   lcd_char_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BUSY_TO(BUSY_TO)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .iPush(iPush), .iChar(iChar),
      .iClearOvf(iClearOvf), .oFull(oFull), .oEmpty(oEmpty), .oCount(oCount),
      .oOverflow(oOverflow), .iLCD_Ready(iLCD_Ready), .oLCD_Write(oLCD_Write),
      .oLCD_Data(oLCD_Data)
   );

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic push(input logic [7:0] c);
      iPush = 1'b1;
      iChar = c;
      tick();
      iPush = 1'b0;
   endtask

   // Model writer: ready drops after each strobe, rises 4 cycles later.
   task automatic drain(input int n);
      int busy = 0;
      int guard = 0;
      int extra = 0;
      logic prevW = 1'b0;
      rx.delete();
      iLCD_Ready = 1'b1;
      while ((rx.size() < n || busy != 0) && guard < 400) begin
         tick();
         guard++;
         if (oLCD_Write) begin
            checks++;
            if (prevW !== 1'b0) begin
               errors++;
               $display("FAIL strobe_consecutive: got 2 high cycles, expected 1");
            end
            rx.push_back(oLCD_Data);
            iLCD_Ready = 1'b0;
            busy = 4;
         end else if (busy > 0) begin
            busy--;
            if (busy == 0) iLCD_Ready = 1'b1;
         end
         prevW = oLCD_Write;
      end
      checks++;
      if (guard >= 400) begin
         errors++;
         $display("FAIL drain_timeout: got %0d bytes, expected %0d", rx.size(), n);
      end
      repeat (8) begin
         tick();
         if (oLCD_Write) extra++;
      end
      checks++;
      if (extra != 0 || rx.size() != n) begin
         errors++;
         $display("FAIL drain_count: got %0d bytes (+%0d late), expected %0d", rx.size(), extra, n);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0; iPush = 1'b0; iChar = 8'h00; iClearOvf = 1'b0; iLCD_Ready = 1'b0;
      repeat (2) tick();
      checks++;
      if ({oFull, oEmpty, oOverflow, oLCD_Write} !== 4'b0100) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0100", {oFull, oEmpty, oOverflow, oLCD_Write});
      end
      checks++;
      if (oCount !== '0 || oLCD_Data !== 8'h00) begin
         errors++;
         $display("FAIL reset_count_data: got %0d/%h expected 0/00", oCount, oLCD_Data);
      end
      Reset_n = 1'b1;
      tick();
   endtask

   task automatic test_latency();
      int strobes = 0;
      iLCD_Ready = 1'b1;
      push(8'h41);
      checks++;
      if (oLCD_Write !== 1'b0 || oCount !== 5'd1) begin
         errors++;
         $display("FAIL lat_edge1: got write=%b count=%0d expected 0/1", oLCD_Write, oCount);
      end
      tick();
      checks++;
      if (oLCD_Write !== 1'b1 || oLCD_Data !== 8'h41 || oCount !== 5'd0) begin
         errors++;
         $display("FAIL lat_edge2: got write=%b data=%h count=%0d expected 1/41/0", oLCD_Write, oLCD_Data, oCount);
      end
      iLCD_Ready = 1'b0;
      tick();
      checks++;
      if (oLCD_Write !== 1'b0 || oLCD_Data !== 8'h41) begin
         errors++;
         $display("FAIL lat_strobe_len: got write=%b data=%h expected 0/41", oLCD_Write, oLCD_Data);
      end
      repeat (5) begin tick(); if (oLCD_Write) strobes++; end
      iLCD_Ready = 1'b1;
      repeat (5) begin tick(); if (oLCD_Write) strobes++; end
      checks++;
      if (strobes != 0) begin
         errors++;
         $display("FAIL lat_no_extra: got %0d strobes expected 0", strobes);
      end
   endtask

   task automatic test_overflow();
      iLCD_Ready = 1'b0;
      for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
      checks++;
      if (oFull !== 1'b1 || oCount !== 5'd16 || oOverflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_full: got full=%b count=%0d ovf=%b expected 1/16/1", oFull, oCount, oOverflow);
      end
      drain(16);
      for (int i = 0; i < 16 && i < rx.size(); i++) begin
         checks++;
         if (rx[i] !== 8'h30 + 8'(i)) begin
            errors++;
            $display("FAIL ovf_order[%0d]: got %h expected %h", i, rx[i], 8'h30 + 8'(i));
         end
      end
      checks++;
      if (oEmpty !== 1'b1 || oOverflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky: got empty=%b ovf=%b expected 1/1", oEmpty, oOverflow);
      end
      iClearOvf = 1'b1;
      tick();
      iClearOvf = 1'b0;
      checks++;
      if (oOverflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear: got %b expected 0", oOverflow);
      end
   endtask

   task automatic test_full_pushpop();
      iLCD_Ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'h50 + 8'(i));
      iLCD_Ready = 1'b1;
      push(8'h60);
      iLCD_Ready = 1'b0;
      checks++;
      if (oCount !== 5'd16 || oFull !== 1'b1 || oOverflow !== 1'b0) begin
         errors++;
         $display("FAIL pp_count: got count=%0d full=%b ovf=%b expected 16/1/0", oCount, oFull, oOverflow);
      end
      checks++;
      if (oLCD_Write !== 1'b1 || oLCD_Data !== 8'h50) begin
         errors++;
         $display("FAIL pp_strobe: got write=%b data=%h expected 1/50", oLCD_Write, oLCD_Data);
      end
      repeat (4) tick();
      drain(16);
      for (int i = 0; i < 16 && i < rx.size(); i++) begin
         checks++;
         if (rx[i] !== 8'h51 + 8'(i)) begin
            errors++;
            $display("FAIL pp_order[%0d]: got %h expected %h", i, rx[i], 8'h51 + 8'(i));
         end
      end
   endtask

   task automatic test_timeout();
      int firstK = -1;
      int strobes = 0;
      logic [7:0] d2 = 8'h00;
      iLCD_Ready = 1'b1;
      iPush = 1'b1; iChar = 8'h61;
      tick();
      iChar = 8'h62;
      tick();
      iPush = 1'b0;
      checks++;
      if (oLCD_Write !== 1'b1 || oLCD_Data !== 8'h61) begin
         errors++;
         $display("FAIL tmo_first: got write=%b data=%h expected 1/61", oLCD_Write, oLCD_Data);
      end
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (oLCD_Write) begin
            strobes++;
            if (firstK < 0) begin firstK = k; d2 = oLCD_Data; end
         end
      end
      checks++;
      if (firstK < BUSY_TO + 2 || firstK > BUSY_TO + 3) begin
         errors++;
         $display("FAIL tmo_gap: got %0d cycles expected %0d..%0d", firstK, BUSY_TO + 2, BUSY_TO + 3);
      end
      checks++;
      if (strobes != 1 || d2 !== 8'h62) begin
         errors++;
         $display("FAIL tmo_second: got %0d strobes data=%h expected 1/62", strobes, d2);
      end
   endtask

   task automatic test_filter();
      logic [7:0] exp [3];
`ifdef LCD_FEED_FILTER_EN
      exp = '{8'h20, 8'h20, 8'h7E};
`else
      exp = '{8'h0A, 8'h7F, 8'h7E};
`endif
      iLCD_Ready = 1'b0;
      push(8'h0A); push(8'h7F); push(8'h7E);
      drain(3);
      for (int i = 0; i < 3 && i < rx.size(); i++) begin
         checks++;
         if (rx[i] !== exp[i]) begin
            errors++;
            $display("FAIL filter[%0d]: got %h expected %h", i, rx[i], exp[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      int strobes = 0;
      iLCD_Ready = 1'b0;
      for (int i = 0; i < 17; i++) push(8'h30 + 8'(i));
      iLCD_Ready = 1'b1;
      tick();
      iLCD_Ready = 1'b0;
      repeat (3) tick();
      checks++;
      if (oLCD_Data !== 8'h30 || oCount !== 5'd15 || oOverflow !== 1'b1) begin
         errors++;
         $display("FAIL arst_pre: got data=%h count=%0d ovf=%b expected 30/15/1", oLCD_Data, oCount, oOverflow);
      end
      #2 Reset_n = 1'b0;
      #1;
      checks++;
      if ({oFull, oEmpty, oOverflow, oLCD_Write} !== 4'b0100 || oCount !== '0 || oLCD_Data !== 8'h00) begin
         errors++;
         $display("FAIL arst_outputs: got flags=%b count=%0d data=%h expected 0100/0/00",
                  {oFull, oEmpty, oOverflow, oLCD_Write}, oCount, oLCD_Data);
      end
      tick();
      Reset_n = 1'b1;
      iLCD_Ready = 1'b1;
      repeat (6) begin tick(); if (oLCD_Write) strobes++; end
      checks++;
      if (strobes != 0 || oEmpty !== 1'b1) begin
         errors++;
         $display("FAIL arst_discard: got %0d strobes empty=%b expected 0/1", strobes, oEmpty);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_overflow();
      test_full_pushpop();
      test_timeout();
      test_filter();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
